// File: rtl/dmac_mc_read_req_gen.sv
// Multi-channel AXI read-request generator: splits per-channel commands into AR bursts
// (length-capped, 4 KiB-safe for INCR) and shares one AR port round-robin, one burst per grant.
module dmac_mc_read_req_gen #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int CHANNEL_COUNT = 4,
  parameter int MAX_BURST_LEN = 16,
  localparam int MAX_SIZE     = $clog2(DATA_WD / 8),
  localparam int ID_WD        = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNEL_COUNT-1:0]         cmd_valid_i,
  output logic [CHANNEL_COUNT-1:0]         cmd_ready_o,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] cmd_src_addr_i,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] cmd_len_i,
  input  logic [CHANNEL_COUNT*2-1:0]       cmd_burst_i,
  input  logic [CHANNEL_COUNT*3-1:0]       cmd_size_i,
  output logic                             rd_req_valid_o,
  input  logic                             rd_req_ready_i,
  output logic [ID_WD-1:0]                 rd_req_id_o,
  output logic [ADDR_WD-1:0]               rd_req_addr_o,
  output logic [1:0]                       rd_req_burst_o,
  output logic [7:0]                       rd_req_len_o,
  output logic [2:0]                       rd_req_size_o,
  output logic [CHANNEL_COUNT-1:0]         ch_done_o
);

  localparam logic [ADDR_WD-1:0] MAX_LEN_C   = ADDR_WD'(MAX_BURST_LEN);
  localparam logic [ADDR_WD-1:0] FIXED_CAP_C = ADDR_WD'(16);

  typedef enum logic {CH_IDLE = 1'b0, CH_ACTIVE = 1'b1} ch_state_e;

  ch_state_e          state_q [CHANNEL_COUNT];
  ch_state_e          state_d [CHANNEL_COUNT];
  logic [ADDR_WD-1:0] addr_q  [CHANNEL_COUNT];
  logic [ADDR_WD-1:0] addr_d  [CHANNEL_COUNT];
  logic [ADDR_WD-1:0] rem_q   [CHANNEL_COUNT];
  logic [ADDR_WD-1:0] rem_d   [CHANNEL_COUNT];
  logic [1:0]         burst_q [CHANNEL_COUNT];
  logic [1:0]         burst_d [CHANNEL_COUNT];
  logic [2:0]         size_q  [CHANNEL_COUNT];
  logic [2:0]         size_d  [CHANNEL_COUNT];

  logic [CHANNEL_COUNT-1:0] active_s;
  logic [CHANNEL_COUNT-1:0] accept_s;
  logic                     grant_valid_s;
  logic [ID_WD-1:0]         grant_id_s;
  logic                     load_s;
  logic                     issue_s;
  logic [ADDR_WD-1:0]       g_addr_s;
  logic [ADDR_WD-1:0]       g_rem_s;
  logic [1:0]               g_burst_s;
  logic [2:0]               g_size_s;
  logic [8:0]               g_beats_s;
  logic [ADDR_WD-1:0]       g_align_mask_s;
  logic [ADDR_WD-1:0]       g_next_addr_s;

  logic                     req_valid_q, req_valid_d;
  logic [ID_WD-1:0]         req_id_q, req_id_d;
  logic [ADDR_WD-1:0]       req_addr_q, req_addr_d;
  logic [1:0]               req_burst_q, req_burst_d;
  logic [7:0]               req_len_q, req_len_d;
  logic [2:0]               req_size_q, req_size_d;
  logic                     req_last_q, req_last_d;
  logic [CHANNEL_COUNT-1:0] ch_done_q, ch_done_d;
  logic [ID_WD-1:0]         rr_ptr_q, rr_ptr_d;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
  endfunction

  // WRAP and the reserved encoding both fall back to INCR
  function automatic logic [1:0] clamp_burst(input logic [1:0] burst);
    return burst[1] ? 2'b01 : burst;
  endfunction

  // The 4K term floors from the unaligned address; the final clamp to one beat only
  // matters when the start sits inside the last partial transfer of a 4K page.
  function automatic logic [8:0] calc_beats(input logic [ADDR_WD-1:0] addr,
                                            input logic [ADDR_WD-1:0] rem,
                                            input logic [1:0]         burst,
                                            input logic [2:0]         size);
    logic [12:0]        to_4k;
    logic [ADDR_WD-1:0] cap;
    to_4k = (13'd4096 - {1'b0, addr[11:0]}) >> size;
    cap   = (burst == 2'b00) ? FIXED_CAP_C : ADDR_WD'(to_4k);
    cap   = (cap > MAX_LEN_C) ? MAX_LEN_C : cap;
    cap   = (cap > rem) ? rem : cap;
    cap   = (cap == '0) ? ADDR_WD'(1) : cap;
    return cap[8:0];
  endfunction

  assign load_s  = !req_valid_q || rd_req_ready_i;
  assign issue_s = load_s && grant_valid_s;

  // Channel state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) state_q[c] <= CH_IDLE;
    end else begin
      for (int c = 0; c < CHANNEL_COUNT; c++) state_q[c] <= state_d[c];
    end
  end

  // Channel next state; zero-length commands never leave IDLE
  always_comb begin
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        CH_IDLE:   state_d[c] = (accept_s[c] && (cmd_len_i[c*ADDR_WD +: ADDR_WD] != '0))
                                ? CH_ACTIVE : CH_IDLE;
        CH_ACTIVE: state_d[c] = (issue_s && (grant_id_s == ID_WD'(c)) &&
                                 (g_rem_s == ADDR_WD'(g_beats_s))) ? CH_IDLE : CH_ACTIVE;
        default:   state_d[c] = CH_IDLE;
      endcase
    end
  end

  // Channel state decode
  always_comb begin
    cmd_ready_o = '0;
    active_s    = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      cmd_ready_o[c] = (state_q[c] == CH_IDLE);
      active_s[c]    = (state_q[c] == CH_ACTIVE);
    end
  end

  assign accept_s = cmd_valid_i & cmd_ready_o;

  // Round-robin grant: first active channel after rr_ptr, wrapping
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    for (int i = 1; i <= CHANNEL_COUNT; i++) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        grant_id_s    = (!grant_valid_s && active_s[c] &&
                         (c == (int'(rr_ptr_q) + i) % CHANNEL_COUNT)) ? ID_WD'(c) : grant_id_s;
        grant_valid_s = grant_valid_s ||
                        (active_s[c] && (c == (int'(rr_ptr_q) + i) % CHANNEL_COUNT));
      end
    end
  end

  // Granted channel's burst and its follow-on address (aligned after the first burst)
  always_comb begin
    g_addr_s       = addr_q[grant_id_s];
    g_rem_s        = rem_q[grant_id_s];
    g_burst_s      = burst_q[grant_id_s];
    g_size_s       = size_q[grant_id_s];
    g_beats_s      = calc_beats(g_addr_s, g_rem_s, g_burst_s, g_size_s);
    g_align_mask_s = ~((ADDR_WD'(1) << g_size_s) - ADDR_WD'(1));
    g_next_addr_s  = (g_burst_s == 2'b00) ? g_addr_s
                   : ((g_addr_s & g_align_mask_s) + (ADDR_WD'(g_beats_s) << g_size_s));
  end

  // Channel context next value
  always_comb begin
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      addr_d[c]  = addr_q[c];
      rem_d[c]   = rem_q[c];
      burst_d[c] = burst_q[c];
      size_d[c]  = size_q[c];
      if (accept_s[c]) begin
        addr_d[c]  = cmd_src_addr_i[c*ADDR_WD +: ADDR_WD];
        rem_d[c]   = cmd_len_i[c*ADDR_WD +: ADDR_WD];
        burst_d[c] = clamp_burst(cmd_burst_i[c*2 +: 2]);
        size_d[c]  = clamp_size(cmd_size_i[c*3 +: 3]);
      end else if (issue_s && (grant_id_s == ID_WD'(c))) begin
        addr_d[c] = g_next_addr_s;
        rem_d[c]  = g_rem_s - ADDR_WD'(g_beats_s);
      end else begin
        addr_d[c] = addr_q[c];
        rem_d[c]  = rem_q[c];
      end
    end
  end

  // Channel context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        addr_q[c]  <= '0;
        rem_q[c]   <= '0;
        burst_q[c] <= 2'b00;
        size_q[c]  <= 3'b000;
      end
    end else begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        addr_q[c]  <= addr_d[c];
        rem_q[c]   <= rem_d[c];
        burst_q[c] <= burst_d[c];
        size_q[c]  <= size_d[c];
      end
    end
  end

  // AR stage next value, round-robin pointer and done pulses
  always_comb begin
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_addr_d  = req_addr_q;
    req_burst_d = req_burst_q;
    req_len_d   = req_len_q;
    req_size_d  = req_size_q;
    req_last_d  = req_last_q;
    if (load_s) begin
      req_valid_d = grant_valid_s;
      if (grant_valid_s) begin
        req_id_d    = grant_id_s;
        req_addr_d  = g_addr_s;
        req_burst_d = g_burst_s;
        req_len_d   = 8'(g_beats_s - 9'd1);
        req_size_d  = g_size_s;
        req_last_d  = (g_rem_s == ADDR_WD'(g_beats_s));
      end else begin
        req_last_d  = 1'b0;
      end
    end else begin
      req_valid_d = req_valid_q;
    end
    rr_ptr_d = issue_s ? grant_id_s : rr_ptr_q;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      ch_done_d[c] = (accept_s[c] && (cmd_len_i[c*ADDR_WD +: ADDR_WD] == '0)) ||
                     (req_valid_q && rd_req_ready_i && req_last_q && (req_id_q == ID_WD'(c)));
    end
  end

  // AR stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_addr_q  <= '0;
      req_burst_q <= 2'b00;
      req_len_q   <= 8'h00;
      req_size_q  <= 3'b000;
      req_last_q  <= 1'b0;
      ch_done_q   <= '0;
      rr_ptr_q    <= ID_WD'(CHANNEL_COUNT - 1);
    end else begin
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_addr_q  <= req_addr_d;
      req_burst_q <= req_burst_d;
      req_len_q   <= req_len_d;
      req_size_q  <= req_size_d;
      req_last_q  <= req_last_d;
      ch_done_q   <= ch_done_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rd_req_valid_o = req_valid_q;
  assign rd_req_id_o    = req_id_q;
  assign rd_req_addr_o  = req_addr_q;
  assign rd_req_burst_o = req_burst_q;
  assign rd_req_len_o   = req_len_q;
  assign rd_req_size_o  = req_size_q;
  assign ch_done_o      = ch_done_q;

endmodule
